// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths,
// common to the APB_Protocol master and the apb_mem_slave completer.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [0:0] {
    APB_IDLE   = 1'b0,
    APB_ACCESS = 1'b1
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_slv_mem.sv
// Word array behind the APB completer: synchronous write port and
// asynchronous (combinational) read port. Contents have no reset.
module apb_slv_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Commit one word on the rising edge when a write is granted
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : apb_slv_mem

// File: rtl/apb_mem_slave.sv
// APB completer with a DEPTH-word array and WAIT_STATES wait cycles per access.
// Out-of-range addresses complete with PSLVERR rather than stalling the bus.
// Optional build macro APB_SLV_VALID_TRACK_EN: keeps a per-word written flag
// and reports reads of never-written in-range words as errors (PRDATA=0).
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int LIMIT_W = ADDR_W + 1;

  localparam logic [LIMIT_W-1:0] LIMIT    = LIMIT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_prdata;

  logic              w_setup;
  logic              w_ready;
  logic              w_slverr;
  logic              w_commit;
  logic              w_addr_err;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  // Setup phase is only recognised from IDLE; a lone PENABLE is ignored
  assign w_setup    = (r_state == APB_IDLE) & PSEL & ~PENABLE;
  assign w_idx      = PADDR[IDX_W-1:0];
  assign w_addr_err = ({1'b0, PADDR} >= LIMIT);

  // The write lands on the completing edge, using only the values latched at setup
  assign w_commit = (r_state == APB_ACCESS) & PSEL & PENABLE & w_ready &
                    r_write & ~r_err;

`ifdef APB_SLV_VALID_TRACK_EN
  logic [DEPTH-1:0] r_valid;
  logic             w_unwritten;

  assign w_unwritten = ~w_addr_err & ~PWRITE & ~r_valid[w_idx];
  assign w_err       = w_addr_err | w_unwritten;

  // Written-flag vector: cleared by reset, set by each committed write
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_valid <= '0;
    end else if (w_commit) begin
      r_valid[r_idx] <= 1'b1;
    end
  end
`else
  assign w_err = w_addr_err;
`endif

  apb_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (PCLK),
    .we    (w_commit),
    .waddr (r_idx),
    .wdata (r_wdata),
    .raddr (w_idx),
    .rdata (w_rdata)
  );

  // FSM state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= APB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: enter ACCESS on setup, leave on completion or on PSEL drop
  always_comb begin
    w_next = r_state;
    case (r_state)
      APB_IDLE: begin
        if (w_setup) begin
          w_next = APB_ACCESS;
        end else begin
          w_next = APB_IDLE;
        end
      end
      APB_ACCESS: begin
        if (!PSEL) begin
          w_next = APB_IDLE;
        end else if (PENABLE && w_ready) begin
          w_next = APB_IDLE;
        end else begin
          w_next = APB_ACCESS;
        end
      end
      default: w_next = APB_IDLE;
    endcase
  end

  // FSM outputs: ready and error response decoded from registers only
  always_comb begin
    w_ready  = 1'b0;
    w_slverr = 1'b0;
    case (r_state)
      APB_ACCESS: begin
        w_ready  = (r_cnt == CNT_MAX);
        w_slverr = (r_cnt == CNT_MAX) & r_err;
      end
      APB_IDLE: begin
        w_ready  = 1'b0;
        w_slverr = 1'b0;
      end
      default: begin
        w_ready  = 1'b0;
        w_slverr = 1'b0;
      end
    endcase
  end

  // Transfer context latched at setup, read data fetched early, wait counter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt    <= CNT_ZERO;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_prdata <= '0;
    end else if (w_setup) begin
      r_cnt   <= CNT_ZERO;
      r_idx   <= w_idx;
      r_write <= PWRITE;
      r_wdata <= PWDATA;
      r_err   <= w_err;
      if (!PWRITE) begin
        r_prdata <= w_err ? '0 : w_rdata;
      end
    end else if ((r_state == APB_ACCESS) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign PREADY  = w_ready;
  assign PSLVERR = w_slverr;
  assign PRDATA  = r_prdata;

endmodule : apb_mem_slave
